// File: rtl/id_hazard_scoreboard_pkg.sv
// rtl/id_hazard_scoreboard_pkg.sv - shared constants and helpers for the ID hazard scoreboard
package id_hazard_scoreboard_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_NUM_FWD = 2;
  localparam int DEF_MAX_LAT = 3;
  localparam int ZERO_REG    = 0;

  localparam logic STALL        = 1'b1;
  localparam logic NOT_STOP     = 1'b0;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

  // Countdown width able to hold every latency 0..max_lat.
  function automatic int lat_w(input int max_lat);
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// rtl/id_hazard_scoreboard_if.sv - decode-side bus of the ID hazard scoreboard
// master = decode/regfile/forwarding side, slave = scoreboard.
interface id_hazard_scoreboard_if
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int LAT_W   = lat_w(MAX_LAT)
) ();

  logic                      pipe_hold_in;
  logic                      flush_in;
  logic                      issue_valid_in;
  logic [REG_AW-1:0]         issue_rd_in;
  logic [LAT_W-1:0]          issue_lat_in;
  logic                      rs1_read_in;
  logic                      rs2_read_in;
  logic [REG_AW-1:0]         rs1_addr_in;
  logic [REG_AW-1:0]         rs2_addr_in;
  logic [XLEN-1:0]           rf_rs1_data_in;
  logic [XLEN-1:0]           rf_rs2_data_in;
  logic [NUM_FWD-1:0]        fwd_valid_in;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr_in;
  logic [NUM_FWD*XLEN-1:0]   fwd_data_in;
  logic [XLEN-1:0]           rs1_val_out;
  logic [XLEN-1:0]           rs2_val_out;
  logic                      stall_req_out;
  logic [(1<<REG_AW)-1:0]    busy_mask_out;
  logic [31:0]               stall_cnt_out;

  modport master (
    output pipe_hold_in, flush_in, issue_valid_in, issue_rd_in, issue_lat_in,
           rs1_read_in, rs2_read_in, rs1_addr_in, rs2_addr_in,
           rf_rs1_data_in, rf_rs2_data_in, fwd_valid_in, fwd_addr_in, fwd_data_in,
    input  rs1_val_out, rs2_val_out, stall_req_out, busy_mask_out, stall_cnt_out
  );

  modport slave (
    input  pipe_hold_in, flush_in, issue_valid_in, issue_rd_in, issue_lat_in,
           rs1_read_in, rs2_read_in, rs1_addr_in, rs2_addr_in,
           rf_rs1_data_in, rf_rs2_data_in, fwd_valid_in, fwd_addr_in, fwd_data_in,
    output rs1_val_out, rs2_val_out, stall_req_out, busy_mask_out, stall_cnt_out
  );

endinterface

// File: rtl/id_hazard_scoreboard_operand_resolve.sv
// rtl/id_hazard_scoreboard_operand_resolve.sv - id_operand_resolve: one operand's stall bit and priority forwarding mux
// Port 0 is the youngest stage and wins over older ports carrying the same register.
module id_operand_resolve
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic                      read_i,
  input  logic [REG_AW-1:0]         addr_i,
  input  logic                      busy_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]           val_o,
  output logic                      stall_o
);

  logic hit;

  always_comb begin
    val_o   = rf_data_i;
    stall_o = NOT_STOP;
    hit     = 1'b0;
    if (read_i != READ_ENABLE || addr_i == REG_AW'(ZERO_REG)) begin
      val_o = '0;
    end else if (busy_i) begin
      val_o   = '0;
      stall_o = STALL;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_valid_i[i] && fwd_addr_i[i*REG_AW +: REG_AW] == addr_i) begin
          val_o = fwd_data_i[i*XLEN +: XLEN];
          hit   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - decode-stage countdown scoreboard, operand forwarding and stall request
// Optional stall-cycle statistics counter enabled by HAZARD_STATS_EN.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = DEF_NUM_FWD,
  parameter int MAX_LAT = DEF_MAX_LAT
) (
  input logic                   clk_in,
  input logic                   rst_in,
  id_hazard_scoreboard_if.slave bus
);

  localparam int               LAT_W    = lat_w(MAX_LAT);
  localparam int               NUM_REGS = 1 << REG_AW;
  localparam logic [LAT_W-1:0] LAT_CAP  = LAT_W'(MAX_LAT);

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_mask;
  logic                rs1_busy, rs2_busy, rs1_stall, rs2_stall;
  logic                stall_req, issue_eff;
  logic [LAT_W-1:0]    issue_lat;

  assign rs1_busy = (cnt_q[bus.rs1_addr_in] != '0);
  assign rs2_busy = (cnt_q[bus.rs2_addr_in] != '0);

  id_operand_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs1 (
    .read_i(bus.rs1_read_in), .addr_i(bus.rs1_addr_in), .busy_i(rs1_busy),
    .rf_data_i(bus.rf_rs1_data_in), .fwd_valid_i(bus.fwd_valid_in),
    .fwd_addr_i(bus.fwd_addr_in), .fwd_data_i(bus.fwd_data_in),
    .val_o(bus.rs1_val_out), .stall_o(rs1_stall)
  );

  id_operand_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs2 (
    .read_i(bus.rs2_read_in), .addr_i(bus.rs2_addr_in), .busy_i(rs2_busy),
    .rf_data_i(bus.rf_rs2_data_in), .fwd_valid_i(bus.fwd_valid_in),
    .fwd_addr_i(bus.fwd_addr_in), .fwd_data_i(bus.fwd_data_in),
    .val_o(bus.rs2_val_out), .stall_o(rs2_stall)
  );

  assign stall_req = rs1_stall | rs2_stall;
  assign issue_eff = bus.issue_valid_in & ~stall_req & ~bus.flush_in & ~bus.pipe_hold_in
                   & (bus.issue_rd_in != REG_AW'(ZERO_REG));
  assign issue_lat = (bus.issue_lat_in > LAT_CAP) ? LAT_CAP : bus.issue_lat_in;

  // A new issue to a still-counting register replaces its count (WAW: newest latency wins).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (!bus.pipe_hold_in) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if (issue_eff) cnt_d[bus.issue_rd_in] = issue_lat;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = |cnt_q[r];
  end

  assign bus.busy_mask_out = busy_mask;
  assign bus.stall_req_out = stall_req;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = (stall_req && !bus.pipe_hold_in) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt_out = stall_cnt_q;
`else
  assign bus.stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - directed self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;
  import id_hazard_scoreboard_pkg::*;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_FWD = 2;
  localparam int MAX_LAT = 3;
  localparam int LAT_W   = lat_w(MAX_LAT);
`ifdef HAZARD_STATS_EN
  localparam logic [31:0] EXP_STATS = 32'd5;
`else
  localparam logic [31:0] EXP_STATS = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .MAX_LAT(MAX_LAT)) bus ();

  id_hazard_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .MAX_LAT(MAX_LAT)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  task automatic idle();
    bus.pipe_hold_in   = 1'b0;
    bus.flush_in       = 1'b0;
    bus.issue_valid_in = 1'b0;
    bus.issue_rd_in    = '0;
    bus.issue_lat_in   = '0;
    bus.rs1_read_in    = READ_DISABLE;
    bus.rs2_read_in    = READ_DISABLE;
    bus.rs1_addr_in    = '0;
    bus.rs2_addr_in    = '0;
    bus.rf_rs1_data_in = '0;
    bus.rf_rs2_data_in = '0;
    bus.fwd_valid_in   = '0;
    bus.fwd_addr_in    = '0;
    bus.fwd_data_in    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int port, input logic v, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
    bus.fwd_valid_in[port]                  = v;
    bus.fwd_addr_in[port*REG_AW +: REG_AW]  = a;
    bus.fwd_data_in[port*XLEN +: XLEN]      = d;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rd, input logic [LAT_W-1:0] lat);
    bus.issue_valid_in = 1'b1;
    bus.issue_rd_in    = rd;
    bus.issue_lat_in   = lat;
  endtask

  task automatic test_reset();
    idle();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL reset_busy: got %h want %h", bus.busy_mask_out, 32'h0); end
    n_cmp++; if (bus.stall_cnt_out !== 32'h0) begin n_bad++; $display("FAIL reset_stall_cnt: got %h want %h", bus.stall_cnt_out, 32'h0); end
    @(negedge clk);
    rst = 1'b0;
    step();
    bus.rs1_read_in = READ_ENABLE; bus.rs1_addr_in = 5; bus.rf_rs1_data_in = 32'h11;
    #1;
    n_cmp++; if (bus.rs1_val_out !== 32'h11) begin n_bad++; $display("FAIL reset_rf_val: got %h want %h", bus.rs1_val_out, 32'h11); end
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_req_out); end
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL reset_busy_after: got %h want %h", bus.busy_mask_out, 32'h0); end
  endtask

  task automatic test_countdown();
    issue(5, 2);
    #1;
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL cd_issue_cycle_stall: got %b want 0", bus.stall_req_out); end
    step();
    bus.issue_valid_in = 1'b0;
    #1;
    n_cmp++; if (bus.stall_req_out !== 1'b1) begin n_bad++; $display("FAIL cd_stall1: got %b want 1", bus.stall_req_out); end
    n_cmp++; if (bus.rs1_val_out !== 32'h0) begin n_bad++; $display("FAIL cd_val_while_stall: got %h want 0", bus.rs1_val_out); end
    n_cmp++; if (bus.busy_mask_out !== 32'h20) begin n_bad++; $display("FAIL cd_busy: got %h want %h", bus.busy_mask_out, 32'h20); end
    step();
    n_cmp++; if (bus.stall_req_out !== 1'b1) begin n_bad++; $display("FAIL cd_stall2: got %b want 1", bus.stall_req_out); end
    step();
    set_fwd(1, 1'b1, 5, 32'hAB);
    #1;
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL cd_stall3: got %b want 0", bus.stall_req_out); end
    n_cmp++; if (bus.rs1_val_out !== 32'hAB) begin n_bad++; $display("FAIL cd_fwd_val: got %h want %h", bus.rs1_val_out, 32'hAB); end
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL cd_busy_clear: got %h want 0", bus.busy_mask_out); end
    idle();
  endtask

  task automatic test_fwd_priority();
    step();
    bus.rs2_read_in = READ_ENABLE; bus.rs2_addr_in = 7; bus.rf_rs2_data_in = 32'h77;
    set_fwd(0, 1'b1, 7, 32'h1);
    set_fwd(1, 1'b1, 7, 32'h2);
    #1;
    n_cmp++; if (bus.rs2_val_out !== 32'h1) begin n_bad++; $display("FAIL prio_both: got %h want %h", bus.rs2_val_out, 32'h1); end
    set_fwd(0, 1'b0, 7, 32'h1);
    #1;
    n_cmp++; if (bus.rs2_val_out !== 32'h2) begin n_bad++; $display("FAIL prio_port1: got %h want %h", bus.rs2_val_out, 32'h2); end
    set_fwd(0, 1'b1, 3, 32'h1);
    #1;
    n_cmp++; if (bus.rs2_val_out !== 32'h2) begin n_bad++; $display("FAIL prio_addr_miss: got %h want %h", bus.rs2_val_out, 32'h2); end
    set_fwd(1, 1'b0, 7, 32'h2);
    #1;
    n_cmp++; if (bus.rs2_val_out !== 32'h77) begin n_bad++; $display("FAIL prio_rf: got %h want %h", bus.rs2_val_out, 32'h77); end
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL prio_stall: got %b want 0", bus.stall_req_out); end
    idle();
  endtask

  task automatic test_x0();
    step();
    bus.rs1_read_in = READ_ENABLE; bus.rs1_addr_in = 0; bus.rf_rs1_data_in = 32'h55;
    set_fwd(0, 1'b1, 0, 32'hFF);
    #1;
    n_cmp++; if (bus.rs1_val_out !== 32'h0) begin n_bad++; $display("FAIL x0_val: got %h want 0", bus.rs1_val_out); end
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL x0_stall: got %b want 0", bus.stall_req_out); end
    bus.rs1_read_in = READ_DISABLE; bus.rs1_addr_in = 5;
    #1;
    n_cmp++; if (bus.rs1_val_out !== 32'h0) begin n_bad++; $display("FAIL noread_val: got %h want 0", bus.rs1_val_out); end
    idle();
    issue(0, 3);
    step();
    bus.issue_valid_in = 1'b0;
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL x0_busy: got %h want 0", bus.busy_mask_out); end
  endtask

  task automatic test_waw();
    idle();
    issue(3, 3);
    step();
    n_cmp++; if (bus.busy_mask_out !== 32'h8) begin n_bad++; $display("FAIL waw_busy: got %h want %h", bus.busy_mask_out, 32'h8); end
    issue(3, 0);
    step();
    bus.issue_valid_in = 1'b0;
    bus.rs1_read_in = READ_ENABLE; bus.rs1_addr_in = 3;
    set_fwd(0, 1'b1, 3, 32'h33);
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL waw_override: got %h want 0", bus.busy_mask_out); end
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL lat0_stall: got %b want 0", bus.stall_req_out); end
    n_cmp++; if (bus.rs1_val_out !== 32'h33) begin n_bad++; $display("FAIL lat0_fwd: got %h want %h", bus.rs1_val_out, 32'h33); end
    idle();
  endtask

  task automatic test_hold_and_reset();
    idle();
    issue(9, 2);
    step();
    bus.issue_valid_in = 1'b0;
    bus.rs1_read_in = READ_ENABLE; bus.rs1_addr_in = 9;
    bus.pipe_hold_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus.stall_req_out !== 1'b1) begin n_bad++; $display("FAIL hold_stall[%0d]: got %b want 1", k, bus.stall_req_out); end
      n_cmp++; if (bus.busy_mask_out !== 32'h200) begin n_bad++; $display("FAIL hold_busy[%0d]: got %h want %h", k, bus.busy_mask_out, 32'h200); end
    end
    bus.pipe_hold_in = 1'b0;
    step();
    n_cmp++; if (bus.stall_req_out !== 1'b1) begin n_bad++; $display("FAIL release_stall1: got %b want 1", bus.stall_req_out); end
    step();
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL release_stall2: got %b want 0", bus.stall_req_out); end
    bus.rs1_read_in = READ_DISABLE;
    issue(9, 3);
    step();
    bus.issue_valid_in = 1'b0;
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h200) begin n_bad++; $display("FAIL midrst_pre: got %h want %h", bus.busy_mask_out, 32'h200); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL midrst_busy: got %h want 0", bus.busy_mask_out); end
    n_cmp++; if (bus.stall_cnt_out !== 32'h0) begin n_bad++; $display("FAIL midrst_cnt: got %h want 0", bus.stall_cnt_out); end
    #1 rst = 1'b0;
  endtask

  task automatic test_issue_block();
    idle();
    step();
    issue(4, 2);
    bus.flush_in = 1'b1;
    step();
    bus.flush_in = 1'b0;
    bus.issue_valid_in = 1'b0;
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL flush_busy: got %h want 0", bus.busy_mask_out); end
    issue(4, 2);
    bus.pipe_hold_in = 1'b1;
    step();
    bus.pipe_hold_in = 1'b0;
    bus.issue_valid_in = 1'b0;
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h0) begin n_bad++; $display("FAIL hold_issue_busy: got %h want 0", bus.busy_mask_out); end
    issue(6, 2);
    step();
    bus.rs1_read_in = READ_ENABLE; bus.rs1_addr_in = 6;
    issue(8, 2);
    step();
    bus.issue_valid_in = 1'b0;
    bus.rs1_read_in = READ_DISABLE;
    #1;
    n_cmp++; if (bus.busy_mask_out !== 32'h40) begin n_bad++; $display("FAIL stall_blocks_issue: got %h want %h", bus.busy_mask_out, 32'h40); end
    idle();
  endtask

  task automatic test_stats();
    idle();
    step();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (bus.stall_cnt_out !== 32'h0) begin n_bad++; $display("FAIL stats_start: got %0d want 0", bus.stall_cnt_out); end
    issue(10, 3);
    step();
    bus.issue_valid_in = 1'b0;
    bus.rs1_read_in = READ_ENABLE; bus.rs1_addr_in = 10;
    bus.pipe_hold_in = 1'b1;
    step();
    bus.pipe_hold_in = 1'b0;
    step();
    step();
    step();
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL stats_lat3_done: got %b want 0", bus.stall_req_out); end
    issue(11, 2);
    step();
    bus.issue_valid_in = 1'b0;
    bus.rs1_addr_in = 11;
    step();
    step();
    n_cmp++; if (bus.stall_req_out !== 1'b0) begin n_bad++; $display("FAIL stats_lat2_done: got %b want 0", bus.stall_req_out); end
    n_cmp++; if (bus.stall_cnt_out !== EXP_STATS) begin n_bad++; $display("FAIL stats_count: got %0d want %0d", bus.stall_cnt_out, EXP_STATS); end
    step();
    n_cmp++; if (bus.stall_cnt_out !== EXP_STATS) begin n_bad++; $display("FAIL stats_hold_value: got %0d want %0d", bus.stall_cnt_out, EXP_STATS); end
    idle();
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_fwd_priority();
    test_x0();
    test_waw();
    test_hold_and_reset();
    test_issue_block();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
